reg_wb_ctrl: RTL and testbench

//   Register-file write-port initiator. Merges ALU and load/store results into an
//   in-order write queue. Drains one write per cycle onto regfile we/waddr/wdata.

---
 rtl/reg_wb_ctrl.sv | 135 +++++++++++++
 tb/tb_reg_wb_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-port initiator.
// The ALU and load/store result buses feed one in-order write queue.
// The queue drains one entry per cycle onto the registered we/waddr/wdata outputs.
// Two combinational lookup ports give decode the youngest queued data for an address.
module reg_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_valid,
  input  logic [ADDR_W-1:0]        lsu_waddr,
  input  logic [DATA_W-1:0]        lsu_wdata,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_waddr,
  input  logic [DATA_W-1:0]        alu_wdata,
  output logic                     in_ready,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        raddr1,
  output logic                     hit1,
  output logic [DATA_W-1:0]        fdata1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fdata2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // The queue accepts a cycle's inputs only while two slots are free, so both sources always fit.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [PW-1:0] alu_slot;

  logic          lsu_push;
  logic          alu_push;
  logic          pop;

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign in_ready = rst && (count_reg <= READY_MAX);
  // A write to x0 is accepted by the handshake but never stored.
  assign lsu_push = lsu_valid && in_ready && (lsu_waddr != '0);
  assign alu_push = alu_valid && in_ready && (alu_waddr != '0);
  assign pop      = (count_reg != '0);
  // Load data is older than ALU data in the same cycle, so ALU takes the slot after it.
  assign alu_slot = tail_reg + PW'(lsu_push);
  assign count    = count_reg;

  assign count_next = count_reg + CW'(lsu_push) + CW'(alu_push) - CW'(pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] age;
      logic          valid;

      // Entry storage needs no reset; occupancy is defined by head and count alone.
      always_ff @(posedge clk) begin
        if (lsu_push && (tail_reg == PW'(gi))) begin
          addr_mem[gi] <= lsu_waddr;
          data_mem[gi] <= lsu_wdata;
        end else if (alu_push && (alu_slot == PW'(gi))) begin
          addr_mem[gi] <= alu_waddr;
          data_mem[gi] <= alu_wdata;
        end
      end

      assign age       = PW'(gi) - head_reg;
      assign valid     = (CW'(age) < count_reg);
      assign match1[gi] = valid && (addr_mem[gi] == raddr1);
      assign match2[gi] = valid && (addr_mem[gi] == raddr2);
    end
  endgenerate

  // Queue pointers and occupancy; a reset discards anything still queued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(pop);
      tail_reg  <= tail_reg + PW'(lsu_push) + PW'(alu_push);
      count_reg <= count_next;
    end
  end

  // Register-file write stage: pop the head whenever the queue holds something.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pop) begin
      we    <= 1'b1;
      waddr <= addr_mem[head_reg];
      wdata <= data_mem[head_reg];
    end else begin
      we    <= 1'b0;
    end
  end

  // Lookup walks the queue oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    hit1   = 1'b0;
    fdata1 = '0;
    hit2   = 1'b0;
    fdata2 = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PW'(k);
      if (match1[idx] && (raddr1 != '0)) begin
        hit1   = 1'b1;
        fdata1 = data_mem[idx];
      end
      if (match2[idx] && (raddr2 != '0)) begin
        hit2   = 1'b1;
        fdata2 = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: a queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_wb_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic              hit1;
  logic [DATA_W-1:0] fdata1;
  logic [ADDR_W-1:0] raddr2;
  logic              hit2;
  logic [DATA_W-1:0] fdata2;
  logic [$clog2(DEPTH):0] count;

  reg_wb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .hit1(hit1), .fdata1(fdata1),
    .raddr2(raddr2), .hit2(hit2), .fdata2(fdata2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  ent_t wlog[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                lsu_acc;
  bit                alu_acc;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return (rst === 1'b1) && ((DEPTH - q.size()) >= 2);
  endfunction

  function automatic void look(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      foreach (q[i]) begin
        if (q[i].a == a) begin
          h = 1'b1;
          d = q[i].d;
        end
      end
    end
  endfunction

  // Applies the effect of one clock edge to the model using the inputs present at that edge.
  task automatic model_update();
    bit   rdy;
    ent_t e;
    rdy     = m_ready();
    lsu_acc = lsu_valid && rdy;
    alu_acc = alu_valid && rdy;
    if (rst !== 1'b1) begin
      q.delete();
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      if (q.size() > 0) begin
        e       = q.pop_front();
        m_we    = 1'b1;
        m_waddr = e.a;
        m_wdata = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (lsu_acc && lsu_waddr != 0) q.push_back('{lsu_waddr, lsu_wdata});
      if (alu_acc && alu_waddr != 0) q.push_back('{alu_waddr, alu_wdata});
    end
  endtask

  task automatic compare_all();
    logic              h;
    logic [DATA_W-1:0] d;
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("count", count, q.size());
    chk("in_ready", in_ready, m_ready());
    look(raddr1, h, d);
    chk("hit1", hit1, h);
    chk("fdata1", fdata1, d);
    look(raddr2, h, d);
    chk("hit2", hit2, h);
    chk("fdata2", fdata2, d);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    if (we === 1'b1) wlog.push_back('{waddr, wdata});
    $display("cyc t=%0t rst=%0b lsu=%0b/%0d alu=%0b/%0d rdy=%0b we=%0b waddr=%0d wdata=%h count=%0d",
             $time, rst, lsu_valid, lsu_waddr, alu_valid, alu_waddr, in_ready, we, waddr, wdata, count);
  endtask

  task automatic idle_inputs();
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic dual(input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    lsu_valid = 1'b1; lsu_waddr = la; lsu_wdata = ld;
    alu_valid = 1'b1; alu_waddr = aa; alu_wdata = ad;
  endtask

  initial begin
    int  i;
    int  cyc;
    bit  saw_not_ready;
    rst = 1'b0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    raddr1 = '0; raddr2 = '0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;

    // Reset with entries queued
    tick(); tick();
    rst = 1'b1;
    tick();
    dual(5'd1, 32'hA1, 5'd2, 32'hA2);
    tick();
    chk("pre_reset_count", count, 2);
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("rst_we", we, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst2_we", we, 0);
    chk("rst2_count", count, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single write
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    chk("single_count", count, 1);
    tick();
    chk("single_we", we, 1);
    chk("single_waddr", waddr, 5);
    chk("single_wdata", wdata, 32'hDEAD_BEEF);
    tick();
    chk("single_we_off", we, 0);

    // Dual push to the same register; lookup sees the younger ALU value
    raddr1 = 5'd3;
    dual(5'd3, 32'h11, 5'd3, 32'h22);
    tick();
    idle_inputs();
    chk("dual_count", count, 2);
    chk("dual_hit1", hit1, 1);
    chk("dual_fdata1", fdata1, 32'h22);
    tick();
    chk("dual_w1_addr", waddr, 3);
    chk("dual_w1_data", wdata, 32'h11);
    chk("dual_w1_fdata1", fdata1, 32'h22);
    tick();
    chk("dual_w2_data", wdata, 32'h22);
    chk("dual_w2_hit1", hit1, 0);
    tick();
    chk("dual_we_off", we, 0);

    // x0 filter
    raddr1 = 5'd0;
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("x0_count", count, 0);
    chk("x0_hit1", hit1, 0);
    chk("x0_fdata1", fdata1, 0);
    tick();
    chk("x0_we", we, 0);

    // Backpressure: three dual pushes held until accepted
    wlog.delete();
    i = 0;
    saw_not_ready = 1'b0;
    for (cyc = 0; cyc < 40 && i < 3; cyc++) begin
      dual(5'(2*i+1), 32'(100+2*i), 5'(2*i+2), 32'(101+2*i));
      tick();
      if (lsu_acc) i++;
      if (in_ready === 1'b0) saw_not_ready = 1'b1;
    end
    idle_inputs();
    chk("bp_accepted", i, 3);
    chk("bp_saw_not_ready", saw_not_ready, 1);
    repeat (8) tick();
    chk("bp_nwrites", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      chk("bp_addr", wlog[k].a, k + 1);
      chk("bp_data", wlog[k].d, 100 + k);
    end

    // Reset while three entries are queued
    dual(5'd1, 32'h51, 5'd2, 32'h52);
    tick();
    dual(5'd3, 32'h53, 5'd4, 32'h54);
    tick();
    idle_inputs();
    chk("mid_count", count, 3);
    rst = 1'b0;
    tick();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_count", count, 0);
    rst = 1'b1;
    wlog.delete();
    repeat (5) tick();
    chk("mid_no_residual", wlog.size(), 0);

    // Randomized traffic with upstream holding offers until accepted
    for (int n = 0; n < 600; n++) begin
      if (!lsu_valid || lsu_acc) begin
        lsu_valid = ($urandom_range(0, 9) < 6);
        lsu_waddr = 5'($urandom_range(0, 7));
        lsu_wdata = $urandom;
      end
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_waddr = 5'($urandom_range(0, 7));
        alu_wdata = $urandom;
      end
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      if (rst === 1'b0) rst = ($urandom_range(0, 3) != 0);
      else rst = ($urandom_range(0, 99) >= 3);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
